// File: rtl/ysyx_22050550_icache_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050550_icache_pkg
// Shared definitions for the instruction cache:
//   - FSM state encoding (2 bits)
//   - register/instruction bus widths already used by the core
//   - line geometry (beats per line, beat counter width)
//   - pick_word(): selects the 32-bit instruction out of a two-beat line
// No ports (package).
// ----------------------------------------------------------------------------
package ysyx_22050550_icache_pkg;

  localparam int REG_W      = 64;  // RegBus width
  localparam int INST_W     = 32;  // InstBus width
  localparam int LINE_BEATS = 2;   // 64-bit beats per 16-byte line
  localparam int BEAT_CNT_W = 2;   // counts 0..2, saturating at a full line

  localparam logic [BEAT_CNT_W-1:0] BEATS_PER_LINE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOOKUP   = 2'd1,
    S_MISS_REQ = 2'd2,
    S_REFILL   = 2'd3
  } icache_state_e;

  // Offset bit 3 picks the beat, bit 2 picks the 32-bit half (little-endian).
  function automatic logic [INST_W-1:0] pick_word(
    input logic [REG_W-1:0] beat0,
    input logic [REG_W-1:0] beat1,
    input logic             beat_sel,
    input logic             half_sel
  );
    logic [REG_W-1:0] beat;
    if (beat_sel) begin
      beat = beat1;
    end else begin
      beat = beat0;
    end
    if (half_sel) begin
      return beat[REG_W-1:INST_W];
    end else begin
      return beat[INST_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ysyx_22050550_icache_array.sv
// ----------------------------------------------------------------------------
// ysyx_22050550_icache_array
// Tag/valid and data storage of the direct-mapped instruction cache.
//   clock, reset        : clock, synchronous active-high reset (valid bits only)
//   clear_all           : clears every valid bit at the next edge
//   rd_index            : combinational read port index
//   rd_valid/rd_tag     : valid bit and tag of the indexed line
//   rd_beat0/rd_beat1   : the two 64-bit beats of the indexed line
//   wr_en/wr_index      : synchronous line install
//   wr_tag/wr_valid     : tag and valid bit written with the line
//   wr_beat0/wr_beat1   : line data written
// ----------------------------------------------------------------------------
module ysyx_22050550_icache_array
  import ysyx_22050550_icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 54
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_all,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [REG_W-1:0]   rd_beat0,
  output logic [REG_W-1:0]   rd_beat1,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic [REG_W-1:0]   wr_beat0,
  input  logic [REG_W-1:0]   wr_beat1
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [REG_W-1:0] data_r [LINES][LINE_BEATS];

  // Valid bits: reset and clear_all wipe all lines; an install sets the line's bit.
  always_ff @(posedge clock) begin
    if (reset || clear_all) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_index] <= wr_valid;
    end
  end

  // Tag and data storage, written together when a refill completes.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_r[wr_index]     <= wr_tag;
      data_r[wr_index][0] <= wr_beat0;
      data_r[wr_index][1] <= wr_beat1;
    end
  end

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_beat0 = data_r[rd_index][0];
  assign rd_beat1 = data_r[rd_index][1];

endmodule

// File: rtl/ysyx_22050550_icache.sv
// ----------------------------------------------------------------------------
// ysyx_22050550_icache
// Direct-mapped blocking instruction cache with single-line refill.
//   clock, reset          : clock, synchronous active-high reset
//   valid, addr           : fetch request (accepted only in IDLE)
//   data_ok, data         : registered one-cycle response, {32'h0, instruction}
//   io_flush              : suppresses the pending response
//   fence_i               : invalidates every line (deferred to IDLE if busy)
//   mem_req, mem_addr     : line refill request, held until mem_gnt
//   mem_gnt               : refill request accepted
//   mem_rvalid/rdata/rlast: refill beat stream
// ----------------------------------------------------------------------------
module ysyx_22050550_icache
  import ysyx_22050550_icache_pkg::*;
#(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 4,
  parameter int ADDR_W   = 64,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  output logic              data_ok,
  output logic [REG_W-1:0]  data,
  input  logic              io_flush,
  input  logic              fence_i,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [REG_W-1:0]  mem_rdata,
  input  logic              mem_rlast
);

  icache_state_e state_r, state_nxt_s;

  logic [ADDR_W-1:0]     addr_r;
  logic [REG_W-1:0]      buf0_r, buf1_r;
  logic [BEAT_CNT_W-1:0] cnt_r;
  logic                  data_ok_r;
  logic [REG_W-1:0]      data_r;
  logic                  mem_req_r;
  logic [ADDR_W-1:0]     mem_addr_r;
  logic                  pend_r;
  logic                  flushed_r;

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               arr_valid_s;
  logic [TAG_W-1:0]   arr_tag_s;
  logic [REG_W-1:0]   arr_beat0_s, arr_beat1_s;
  logic               accept_s, hit_s, beat_wr_s, fill_done_s, fill_valid_s;
  logic               clear_all_s, suppress_s;
  logic [REG_W-1:0]   line0_s, line1_s;
  logic [INST_W-1:0]  hit_word_s, fill_word_s;
  logic               unused_ok_s;

  assign idx_s       = addr_r[OFFSET_W +: INDEX_W];
  assign tag_s       = addr_r[ADDR_W-1 -: TAG_W];
  // fence_i wins over a same-cycle request, which is dropped.
  assign accept_s    = valid && !io_flush && !fence_i;
  assign hit_s       = arr_valid_s && (arr_tag_s == tag_s);
  // Beats past the second are ignored.
  assign beat_wr_s   = (state_r == S_REFILL) && mem_rvalid && (cnt_r < BEATS_PER_LINE);
  assign fill_done_s = (state_r == S_REFILL) && mem_rvalid && mem_rlast;
  // An rlast on the very first beat leaves the line incomplete, so it stays invalid.
  assign fill_valid_s = (cnt_r != 2'd0);
  assign clear_all_s  = (state_r == S_IDLE) && (fence_i || pend_r);
  assign suppress_s   = flushed_r || io_flush;
  assign unused_ok_s  = &{1'b0, addr_r[1:0]};

  assign hit_word_s  = pick_word(arr_beat0_s, arr_beat1_s, addr_r[3], addr_r[2]);
  assign fill_word_s = pick_word(line0_s, line1_s, addr_r[3], addr_r[2]);

  assign data_ok  = data_ok_r;
  assign data     = data_r;
  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

  ysyx_22050550_icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .clear_all (clear_all_s),
    .rd_index  (idx_s),
    .rd_valid  (arr_valid_s),
    .rd_tag    (arr_tag_s),
    .rd_beat0  (arr_beat0_s),
    .rd_beat1  (arr_beat1_s),
    .wr_en     (fill_done_s),
    .wr_index  (idx_s),
    .wr_tag    (tag_s),
    .wr_valid  (fill_valid_s),
    .wr_beat0  (line0_s),
    .wr_beat1  (line1_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_LOOKUP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (io_flush || hit_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (mem_gnt) begin
          state_nxt_s = S_REFILL;
        end else begin
          state_nxt_s = S_MISS_REQ;
        end
      end
      S_REFILL: begin
        if (fill_done_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_REFILL;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Line view with the current beat bypassed, so the final beat is usable the cycle it arrives.
  always_comb begin
    line0_s = buf0_r;
    line1_s = buf1_r;
    if (beat_wr_s && (cnt_r == 2'd0)) begin
      line0_s = mem_rdata;
    end else begin
      line0_s = buf0_r;
    end
    if (beat_wr_s && (cnt_r == 2'd1)) begin
      line1_s = mem_rdata;
    end else begin
      line1_s = buf1_r;
    end
  end

  // Request latch, line buffer, bus request and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_r     <= {ADDR_W{1'b0}};
      buf0_r     <= {REG_W{1'b0}};
      buf1_r     <= {REG_W{1'b0}};
      cnt_r      <= 2'd0;
      data_ok_r  <= 1'b0;
      data_r     <= {REG_W{1'b0}};
      mem_req_r  <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
    end else begin
      data_ok_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            addr_r <= addr;
          end
        end
        S_LOOKUP: begin
          if (!io_flush && hit_s) begin
            data_ok_r <= 1'b1;
            data_r    <= {{(REG_W-INST_W){1'b0}}, hit_word_s};
          end else if (!io_flush) begin
            mem_req_r  <= 1'b1;
            mem_addr_r <= {addr_r[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          end
        end
        S_MISS_REQ: begin
          if (mem_gnt) begin
            // A short burst leaves missing beats at zero.
            mem_req_r <= 1'b0;
            cnt_r     <= 2'd0;
            buf0_r    <= {REG_W{1'b0}};
            buf1_r    <= {REG_W{1'b0}};
          end
        end
        S_REFILL: begin
          if (beat_wr_s) begin
            buf0_r <= line0_s;
            buf1_r <= line1_s;
            cnt_r  <= cnt_r + 2'd1;
          end
          if (fill_done_s && !suppress_s) begin
            data_ok_r <= 1'b1;
            data_r    <= {{(REG_W-INST_W){1'b0}}, fill_word_s};
          end
        end
        default: data_ok_r <= 1'b0;
      endcase
    end
  end

  // Deferred invalidate and flushed-response flags; both resolve on the first IDLE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r    <= 1'b0;
      flushed_r <= 1'b0;
    end else if (state_r == S_IDLE) begin
      pend_r    <= 1'b0;
      flushed_r <= 1'b0;
    end else begin
      if (fence_i) begin
        pend_r <= 1'b1;
      end
      if (io_flush && ((state_r == S_MISS_REQ) || (state_r == S_REFILL))) begin
        flushed_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_icache.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050550_icache
// Self-checking bench: a small memory model supplies refill beats, expected
// responses are queued when a request is driven and compared on data_ok.
// ----------------------------------------------------------------------------
module tb_ysyx_22050550_icache;

  localparam int M_NORMAL  = 0;  // plain access
  localparam int M_FLUSH   = 1;  // io_flush between beat 0 and rlast
  localparam int M_FENCE   = 2;  // fence_i during refill
  localparam int M_EARLY   = 3;  // rlast on beat 0
  localparam int M_LKFLUSH = 4;  // io_flush in LOOKUP

  logic        clock = 1'b0;
  logic        reset, valid, io_flush, fence_i, mem_gnt, mem_rvalid, mem_rlast;
  logic [63:0] addr, mem_rdata, data, mem_addr;
  logic        data_ok, mem_req;

  int checks = 0;
  int errors = 0;
  int ok_seen = 0;
  int exp_ok = 0;
  int req_cycles = 0;
  logic [63:0] sb_q[$];

  ysyx_22050550_icache dut (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid),
    .addr       (addr),
    .data_ok    (data_ok),
    .data       (data),
    .io_flush   (io_flush),
    .fence_i    (fence_i),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rlast  (mem_rlast)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: line 0x8000_0000 holds the two reference beats, others a pattern.
  function automatic logic [63:0] beat_val(input logic [63:0] line, input int b);
    if (line == 64'h0000_0000_8000_0000) begin
      return (b == 0) ? 64'h1111_2222_3333_4444 : 64'h5555_6666_7777_8888;
    end
    return {line[31:0], 32'hC0DE_0000 + 32'(b)};
  endfunction

  // Little-endian: byte offset 4 is the upper half of beat 0.
  function automatic logic [63:0] exp_word(input logic [63:0] pc);
    logic [63:0] b;
    b = beat_val({pc[63:4], 4'h0}, int'(pc[3]));
    return pc[2] ? {32'h0, b[63:32]} : {32'h0, b[31:0]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_resp(input logic [63:0] v);
    sb_q.push_back(v);
    exp_ok++;
  endtask

  // Response scoreboard and bus-request activity monitor.
  always @(negedge clock) begin
    if (reset === 1'b0 && data_ok === 1'b1) begin
      ok_seen++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_data_ok", 64'(data_ok), 64'd0);
      end else begin
        check_eq("resp_data", data, sb_q.pop_front());
      end
    end
    if (mem_req === 1'b1) req_cycles++;
  end

  task automatic access(input logic [63:0] pc, input bit miss, input int mode);
    logic [63:0] line;
    int req0;
    line = {pc[63:4], 4'h0};
    req0 = req_cycles;
    valid = 1'b1;
    addr  = pc;
    step();                                   // N+1: LOOKUP
    valid = 1'b0;
    if (mode == M_LKFLUSH) io_flush = 1'b1;
    if (!miss && mode != M_LKFLUSH) expect_resp(exp_word(pc));
    step();                                   // N+2
    io_flush = 1'b0;
    if (mode == M_LKFLUSH || !miss) begin
      check_eq("lookup_ok", 64'(data_ok), (mode == M_LKFLUSH) ? 64'd0 : 64'd1);
      step();
      check_eq("lookup_no_req", 64'(req_cycles - req0), 64'd0);
    end else begin
      check_eq("miss_req", 64'(mem_req), 64'd1);
      check_eq("miss_addr", mem_addr, line);
      step();
      step();
      check_eq("req_held", 64'(mem_req), 64'd1);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      check_eq("req_drop", 64'(mem_req), 64'd0);
      if (mode == M_EARLY) expect_resp(exp_word(pc));
      mem_rvalid = 1'b1;
      mem_rdata  = beat_val(line, 0);
      mem_rlast  = (mode == M_EARLY);
      fence_i    = (mode == M_FENCE);
      step();
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
      fence_i    = 1'b0;
      if (mode != M_EARLY) begin
        if (mode == M_FLUSH) begin
          io_flush = 1'b1;
          step();
          io_flush = 1'b0;
        end
        if (mode != M_FLUSH) expect_resp(exp_word(pc));
        mem_rvalid = 1'b1;
        mem_rdata  = beat_val(line, 1);
        mem_rlast  = 1'b1;
        step();
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
      end
      check_eq("fill_ok", 64'(data_ok), (mode == M_FLUSH) ? 64'd0 : 64'd1);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; addr = 64'd0; io_flush = 1'b0; fence_i = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0; mem_rlast = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_eq("rst_data_ok", 64'(data_ok), 64'd0);
    check_eq("rst_data", data, 64'd0);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    step();

    // Cold miss, then hit on the other beat of the same line.
    access(64'h8000_0004, 1'b1, M_NORMAL);
    access(64'h8000_000C, 1'b0, M_NORMAL);

    // Conflict on index 0 evicts and re-misses.
    access(64'h8000_0400, 1'b1, M_NORMAL);
    access(64'h8000_0004, 1'b1, M_NORMAL);

    // Flushed refill still installs the line.
    access(64'h8000_0010, 1'b1, M_FLUSH);
    access(64'h8000_0018, 1'b0, M_NORMAL);

    // Flush in LOOKUP on a missing line: no response, no bus request.
    access(64'h8000_0400, 1'b1, M_LKFLUSH);
    access(64'h8000_0008, 1'b0, M_NORMAL);

    // fence_i in IDLE drops a same-cycle request and invalidates everything.
    valid = 1'b1; addr = 64'h8000_0004; fence_i = 1'b1;
    step();
    valid = 1'b0; fence_i = 1'b0;
    check_eq("fence_drop_ok", 64'(data_ok), 64'd0);
    step();
    check_eq("fence_drop_req", 64'(mem_req), 64'd0);
    access(64'h8000_0004, 1'b1, M_NORMAL);

    // fence_i mid-refill: response delivered, line invalid afterwards.
    access(64'h8000_0400, 1'b1, M_FENCE);
    access(64'h8000_0400, 1'b1, M_NORMAL);

    // Early rlast: response from beat 0, line left invalid.
    access(64'h8000_0024, 1'b1, M_EARLY);
    access(64'h8000_0024, 1'b1, M_NORMAL);

    step();
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    check_eq("resp_count", 64'(ok_seen), 64'(exp_ok));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
